mem_arbiter: RTL and testbench

Shares the single physical-memory (L2/pmem) port between the I-cache and the D-cache.
- Grants one requester at a time.
- Steers address and write data to memory, and routes the memory response back to the owner only.
- Sits between the two L1 cache controllers and pmem.
- Generates the owner select that drives the address and write-data muxes.

---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_grant.sv | 44 ++++
 rtl/mux2.sv | 20 ++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I-cache/D-cache physical-memory arbiter.
// Optional round-robin arbitration is enabled with ARB_ROUND_ROBIN_EN.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    function automatic arb_owner_t other_owner(input arb_owner_t owner);
        arb_owner_t result;
        if (owner == OWNER_I) begin
            result = OWNER_D;
        end else begin
            result = OWNER_I;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arbiter_grant.sv
// Combinational requester picker for the memory arbiter.
// Round-robin tie-breaking is compiled in only with ARB_ROUND_ROBIN_EN.
module mem_arbiter_grant
    import mem_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_owner_t last_grant,
    output logic       grant_valid,
    output arb_owner_t grant_owner
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // Pick the owner for the next transaction from the live requests.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWNER_D;
`ifdef ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            // Both pending: favour whoever did not win last time.
            grant_owner = other_owner(last_grant);
        end else if (d_req) begin
            grant_owner = OWNER_D;
        end else if (i_req) begin
            grant_owner = OWNER_I;
        end else begin
            grant_owner = OWNER_D;
        end
`else
        if (d_req) begin
            grant_owner = OWNER_D;
        end else if (i_req) begin
            grant_owner = OWNER_I;
        end else begin
            grant_owner = OWNER_D;
        end
`endif
    end

endmodule

// File: rtl/mux2.sv
// Generic two-input multiplexer cell used for the pmem address and write-data paths.
module mux2 #(
    parameter int WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Select b when sel is high, otherwise a.
    always_comb begin
        if (sel) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single pmem port between the I-cache and D-cache controllers.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both caches are waiting.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t state_r;
    arb_state_t state_next_s;
    arb_owner_t owner_sel_s;
    arb_owner_t last_grant_s;
    arb_owner_t grant_owner_s;
    logic       grant_valid_s;
    logic       d_req_s;
    logic       sel_d_s;

    assign d_req_s = d_read | d_write;
    assign sel_d_s = (owner_sel_s == OWNER_D);

    // Read data is broadcast; only the response strobe tells a cache it is theirs.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    mem_arbiter_grant u_grant (
        .i_req       (i_read),
        .d_req       (d_req_s),
        .last_grant  (last_grant_s),
        .grant_valid (grant_valid_s),
        .grant_owner (grant_owner_s)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t last_grant_r;

    // Remember the most recent winner for round-robin tie-breaking.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= OWNER_I;
        end else if ((state_r == ARB_IDLE) && grant_valid_s) begin
            last_grant_r <= grant_owner_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign last_grant_s = last_grant_r;
`else
    assign last_grant_s = OWNER_I;
`endif

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, strobe and owner-select decode.
    always_comb begin
        state_next_s = state_r;
        owner_sel_s  = OWNER_D;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (grant_valid_s) begin
                    if (grant_owner_s == OWNER_D) begin
                        state_next_s = ARB_SERVE_D;
                    end else begin
                        state_next_s = ARB_SERVE_I;
                    end
                end else begin
                    state_next_s = ARB_IDLE;
                end
            end
            ARB_SERVE_I: begin
                owner_sel_s = OWNER_I;
                pmem_read   = 1'b1;
                if (pmem_resp) begin
                    i_resp       = 1'b1;
                    state_next_s = ARB_IDLE;
                end else begin
                    state_next_s = ARB_SERVE_I;
                end
            end
            ARB_SERVE_D: begin
                // Strobes track the owner's live request lines until completion.
                owner_sel_s = OWNER_D;
                pmem_read   = d_read;
                pmem_write  = d_write;
                if (pmem_resp) begin
                    d_resp       = 1'b1;
                    state_next_s = ARB_IDLE;
                end else begin
                    state_next_s = ARB_SERVE_D;
                end
            end
            default: begin
                state_next_s = ARB_IDLE;
            end
        endcase
    end

    mux2 #(.WIDTH(ADDR_WIDTH)) u_addr_mux (
        .sel (sel_d_s),
        .a   (i_address),
        .b   (d_address),
        .y   (pmem_address)
    );

    // The I-cache never writes, so its write-data leg is tied to zero.
    mux2 #(.WIDTH(LINE_WIDTH)) u_wdata_mux (
        .sel (sel_d_s),
        .a   ({LINE_WIDTH{1'b0}}),
        .b   (d_wdata),
        .y   (pmem_wdata)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level reference.
// Build with ARB_ROUND_ROBIN_EN to check the alternating-grant variant.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;
    localparam int NCYC = 4000;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    typedef struct packed {
        logic          owner;   // 0 = I-cache, 1 = D-cache
        logic [LW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   i_done_cnt = 0;
    int   d_done_cnt = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_resp       (i_resp),
        .i_rdata      (i_rdata),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_resp       (d_resp),
        .d_rdata      (d_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Response monitor: pops the scoreboard whenever a response is due or seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                check("single_resp", LW'(i_resp && d_resp), LW'(1'b0));
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", LW'({i_resp, d_resp}), LW'(2'b00));
                end else begin
                    e = exp_q.pop_front();
                    check("resp_i", LW'(i_resp), LW'(e.owner == 1'b0));
                    check("resp_d", LW'(d_resp), LW'(e.owner == 1'b1));
                    check("resp_rdata", (e.owner == 1'b0) ? i_rdata : d_rdata, e.data);
                    if (i_resp) i_done_cnt++;
                    if (d_resp) d_done_cnt++;
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("missing_resp", LW'({i_resp, d_resp}),
                      (e.owner == 1'b0) ? LW'(2'b10) : LW'(2'b01));
            end
        end
    end

    // Stimulus, memory model and transaction-level reference of who owns pmem.
    initial begin
        bit ref_busy;
        bit ref_owner;
        bit ref_last;
        bit mem_busy;
        int mem_cnt;
        int rst_hold;
        bit i_done;
        bit d_done;
        bit stim_on;

        rst = 1'b1;
        i_read = 1'b1;
        i_address = 16'h0040;
        d_read = 1'b0;
        d_write = 1'b0;
        d_address = 16'h0000;
        d_wdata = {LW{1'b0}};
        pmem_rdata = {LW{1'b0}};
        pmem_resp = 1'b0;
        ref_busy = 1'b0;
        ref_owner = 1'b0;
        ref_last = 1'b0;
        mem_busy = 1'b0;
        mem_cnt = 0;
        rst_hold = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (!ref_busy) begin
                check("idle_read", LW'(pmem_read), LW'(1'b0));
                check("idle_write", LW'(pmem_write), LW'(1'b0));
                check("idle_addr", LW'(pmem_address), LW'(d_address));
                check("idle_wdata", pmem_wdata, d_wdata);
            end else if (ref_owner == 1'b0) begin
                check("i_read_strobe", LW'(pmem_read), LW'(1'b1));
                check("i_write_strobe", LW'(pmem_write), LW'(1'b0));
                check("i_addr", LW'(pmem_address), LW'(i_address));
            end else begin
                check("d_read_strobe", LW'(pmem_read), LW'(d_read));
                check("d_write_strobe", LW'(pmem_write), LW'(d_write));
                check("d_addr", LW'(pmem_address), LW'(d_address));
                check("d_wdata", pmem_wdata, d_wdata);
            end
            i_done = i_resp;
            d_done = d_resp;

            if (!mem_busy && !pmem_resp && (pmem_read || pmem_write)) begin
                mem_busy = 1'b1;
                mem_cnt = $urandom_range(0, 5);
            end

            // Reference: an idle arbiter grants at most one waiting cache per cycle.
            if (rst) begin
                ref_busy = 1'b0;
                ref_last = 1'b0;
            end else if (ref_busy) begin
                if (pmem_resp) ref_busy = 1'b0;
            end else if (i_read || d_read || d_write) begin
                if (i_read && (d_read || d_write)) begin
`ifdef ARB_ROUND_ROBIN_EN
                    ref_owner = ~ref_last;
`else
                    ref_owner = 1'b1;
`endif
                end else begin
                    ref_owner = (d_read || d_write);
                end
                ref_last = ref_owner;
                ref_busy = 1'b1;
            end

            @(posedge clk);
            #1;
            stim_on = (cyc < NCYC - 100);

            if (rst_hold > 0) begin
                rst_hold--;
            end else if (stim_on && cyc > 20 && $urandom_range(0, 79) == 0) begin
                rst_hold = $urandom_range(1, 2);
            end
            rst = (cyc < 1) || (rst_hold > 0);
            if (rst) rst_hold = (rst_hold > 0) ? rst_hold : 0;

            pmem_resp = 1'b0;
            pmem_rdata = rand_line();
            if (mem_busy) begin
                if (rst) begin
                    // Stale completion lands in the first idle cycle after reset.
                    mem_cnt = 0;
                end else if (mem_cnt == 0) begin
                    pmem_resp = 1'b1;
                    mem_busy = 1'b0;
                    if (ref_busy) exp_q.push_back({ref_owner, pmem_rdata});
                end else begin
                    mem_cnt--;
                end
            end

            if (i_done) begin
                i_read = 1'b0;
            end else if (!i_read && stim_on && $urandom_range(0, 1) == 1) begin
                i_read = 1'b1;
                i_address = AW'($urandom());
            end
            if (d_done) begin
                d_read = 1'b0;
                d_write = 1'b0;
            end else if (!(d_read || d_write) && stim_on && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) d_read = 1'b1;
                else d_write = 1'b1;
                d_address = AW'($urandom());
                d_wdata = rand_line();
            end
        end

        @(negedge clk);
        check("i_completions_seen", LW'(i_done_cnt > 0), LW'(1'b1));
        check("d_completions_seen", LW'(d_done_cnt > 0), LW'(1'b1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
